// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the sequential radix-8 Booth multiplier.
//   mult_op_e : RV32M multiply mode as carried on funct3[1:0]
//   mult_st_e : control FSM states
//   ndig()    : number of radix-8 Booth digits (= iteration cycles) for a
//               given operand width, ceil((width+2)/3)
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } mult_st_e;

    // ceil((width+2)/3) written with integer arithmetic.
    function automatic int ndig(input int width);
        return (width + 4) / 3;
    endfunction

endpackage

// File: rtl/booth_r8_digit_sel.sv
// ---------------------------------------------------------------------------
// booth_r8_digit_sel
// Combinational radix-8 Booth recoder and multiple selector.
//   window   in  4     : {b[3i+2], b[3i+1], b[3i], b[3i-1]}
//   a_ext    in  DW    : multiplicand (sign/zero-extended, already at the
//                        weight of the current digit)
//   a3_ext   in  DW    : 3x the multiplicand at the same weight
//   mult_mag out DW    : |d| * a_ext, |d| in {0..4}
//   neg      out 1     : digit is negative; caller adds the two's complement
// ---------------------------------------------------------------------------
module booth_r8_digit_sel #(
    parameter int DW = 64
) (
    input  logic [3:0]    window,
    input  logic [DW-1:0] a_ext,
    input  logic [DW-1:0] a3_ext,
    output logic [DW-1:0] mult_mag,
    output logic          neg
);

    // d = -4*w[3] + 2*w[2] + w[1] + w[0]
    always_comb begin
        mult_mag = '0;
        neg      = 1'b0;
        case (window)
            4'b0000, 4'b1111: begin mult_mag = '0;            neg = 1'b0; end
            4'b0001, 4'b0010: begin mult_mag = a_ext;         neg = 1'b0; end
            4'b0011, 4'b0100: begin mult_mag = a_ext << 1;    neg = 1'b0; end
            4'b0101, 4'b0110: begin mult_mag = a3_ext;        neg = 1'b0; end
            4'b0111:          begin mult_mag = a_ext << 2;    neg = 1'b0; end
            4'b1000:          begin mult_mag = a_ext << 2;    neg = 1'b1; end
            4'b1001, 4'b1010: begin mult_mag = a3_ext;        neg = 1'b1; end
            4'b1011, 4'b1100: begin mult_mag = a_ext << 1;    neg = 1'b1; end
            4'b1101, 4'b1110: begin mult_mag = a_ext;         neg = 1'b1; end
            default:          begin mult_mag = '0;            neg = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mult_radix8_seq.sv
// ---------------------------------------------------------------------------
// mult_radix8_seq
// Sequential radix-8 Booth multiplier for RV32M (MUL/MULH/MULHSU/MULHU),
// retiring one Booth digit per cycle.
//   clk        in  1      clock
//   rst_n      in  1      synchronous active-low reset
//   in_valid   in  1      operation request
//   in_ready   out 1      high only in IDLE
//   oper_a     in  WIDTH  multiplicand (rs1)
//   oper_b     in  WIDTH  multiplier (rs2)
//   fuct3      in  2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   flush      in  1      abort the operation in PRE/ITER/DONE
//   out_valid  out 1      result available (DONE)
//   out_ready  in  1      consumer takes the result
//   mult_o     out WIDTH  selected product half, held while out_valid
//   mult_busy  out 1      high in PRE and ITER
// Latency: accept edge T, PRE in the following cycle, NDIG ITER cycles,
// then DONE (out_valid) in the (NDIG+2)th cycle after the accept edge.
// ---------------------------------------------------------------------------
module mult_radix8_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    input  logic [1:0]       fuct3,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mult_o,
    output logic             mult_busy
);

    localparam int NDIG = ndig(WIDTH);
    localparam int PW   = 2 * WIDTH;           // product / accumulator width
    localparam int BW   = 3 * NDIG;            // extended multiplier width
    localparam int CW   = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    mult_st_e          state_reg, state_next;
    mult_op_e          op_reg;
    logic [PW-1:0]     a_reg;                  // multiplicand at weight 8^i
    logic [PW-1:0]     a3_reg;                 // 3x multiplicand at weight 8^i
    logic [BW-1:0]     b_reg;                  // unconsumed multiplier digits
    logic              b_prev_reg;             // b[3i-1] for the current window
    logic [PW-1:0]     acc_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  mult_o_reg;

    // Operand extension at accept. The extended A (WIDTH+2 bits) is widened
    // straight to the accumulator width: everything is computed modulo
    // 2^(2*WIDTH), so the extra sign bits carry no new information.
    mult_op_e          op_in;
    logic              a_sgn, b_sgn;
    logic [PW-1:0]     a_ext;
    logic [BW-1:0]     b_ext;

    assign op_in = mult_op_e'(fuct3);
    assign a_sgn = (op_in != OP_MULHU) & oper_a[WIDTH-1];
    assign b_sgn = ((op_in == OP_MUL) || (op_in == OP_MULH)) & oper_b[WIDTH-1];
    assign a_ext = {{(PW-WIDTH){a_sgn}}, oper_a};
    assign b_ext = {{(BW-WIDTH){b_sgn}}, oper_b};

    // Digit selection and accumulation.
    logic [PW-1:0]     mult_mag;
    logic              mult_neg;
    logic [PW-1:0]     acc_sum;
    logic              last_digit;

    booth_r8_digit_sel #(
        .DW (PW)
    ) u_digit_sel (
        .window   ({b_reg[2:0], b_prev_reg}),
        .a_ext    (a_reg),
        .a3_ext   (a3_reg),
        .mult_mag (mult_mag),
        .neg      (mult_neg)
    );

    // Negative digit: add ~mag + 1.
    assign acc_sum    = acc_reg + (mult_mag ^ {PW{mult_neg}}) + {{(PW-1){1'b0}}, mult_neg};
    assign last_digit = (state_reg == ST_ITER) && (cnt_reg == CNT_LAST) && !flush;

    // Next-state logic; flush outranks out_ready in DONE and is ignored in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)                  state_next = ST_PRE;
            ST_PRE:  state_next = flush ? ST_IDLE : ST_ITER;
            ST_ITER: begin
                if (flush)                          state_next = ST_IDLE;
                else if (cnt_reg == CNT_LAST)       state_next = ST_DONE;
            end
            ST_DONE: if (flush || out_ready)        state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_MUL;
            a_reg      <= '0;
            a3_reg     <= '0;
            b_reg      <= '0;
            b_prev_reg <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            mult_o_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op_in;
                        a_reg  <= a_ext;
                        b_reg  <= b_ext;
                    end
                end
                ST_PRE: begin
                    a3_reg     <= a_reg + {a_reg[PW-2:0], 1'b0};
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                    b_prev_reg <= 1'b0;
                end
                ST_ITER: begin
                    // Move both multiples up one radix-8 weight and expose
                    // the next multiplier window at the bottom of b_reg.
                    acc_reg    <= acc_sum;
                    a_reg      <= a_reg << 3;
                    a3_reg     <= a3_reg << 3;
                    b_reg      <= b_reg >> 3;
                    b_prev_reg <= b_reg[2];
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        mult_o_reg <= (op_reg == OP_MUL) ? acc_sum[WIDTH-1:0]
                                                         : acc_sum[PW-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs decode registers only.
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign mult_busy = (state_reg == ST_PRE) || (state_reg == ST_ITER);
    assign mult_o    = mult_o_reg;

endmodule

// File: tb/tb_mult_radix8_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_radix8_seq
// Drives a WIDTH=32 and a WIDTH=16 instance of mult_radix8_seq. A phase
// model (cycles since accept) and a wide-arithmetic reference product give
// the expected in_ready/mult_busy/out_valid/mult_o every cycle; directed
// vectors also carry hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_mult_radix8_seq;

    // out_valid is first seen in the (NDIG+2)th cycle after the accept edge:
    // 12+2 at WIDTH=32, 6+2 at WIDTH=16.
    localparam int LAT32 = 14;
    localparam int LAT16 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid_s  [2] = '{1'b0, 1'b0};
    logic        flush_s     [2] = '{1'b0, 1'b0};
    logic        out_ready_s [2] = '{1'b0, 1'b0};
    logic [31:0] a_s         [2] = '{32'd0, 32'd0};
    logic [31:0] b_s         [2] = '{32'd0, 32'd0};
    logic [1:0]  op_s        [2] = '{2'd0, 2'd0};
    bit          lit_en_s    [2] = '{1'b0, 1'b0};
    logic [31:0] lit_s       [2] = '{32'd0, 32'd0};

    logic        in_ready32, out_valid32, busy32;
    logic [31:0] mult_o32;
    logic        in_ready16, out_valid16, busy16;
    logic [15:0] mult_o16;

    mult_radix8_seq #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready32),
        .oper_a    (a_s[0]),
        .oper_b    (b_s[0]),
        .fuct3     (op_s[0]),
        .flush     (flush_s[0]),
        .out_valid (out_valid32),
        .out_ready (out_ready_s[0]),
        .mult_o    (mult_o32),
        .mult_busy (busy32)
    );

    mult_radix8_seq #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready16),
        .oper_a    (a_s[1][15:0]),
        .oper_b    (b_s[1][15:0]),
        .fuct3     (op_s[1]),
        .flush     (flush_s[1]),
        .out_valid (out_valid16),
        .out_ready (out_ready_s[1]),
        .mult_o    (mult_o16),
        .mult_busy (busy16)
    );

    // ---------------- reference model ----------------
    int          ph         [2] = '{0, 0};   // 0 idle, k = k-th cycle after accept
    logic [31:0] exp_res    [2] = '{32'd0, 32'd0};
    bit          exp_lit_en [2] = '{1'b0, 1'b0};
    logic [31:0] exp_lit    [2] = '{32'd0, 32'd0};
    bit          zero_ok    [2] = '{1'b1, 1'b1}; // mult_o still at reset value
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_mis = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT32 : LAT16;
    endfunction

    // Product of w-bit operands in 128-bit arithmetic, then the half
    // selected by the mode.
    function automatic logic [31:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic [1:0] op);
        logic [127:0] mask, ae, be, p;
        mask = (128'd1 << w) - 128'd1;
        ae   = {96'd0, a} & mask;
        be   = {96'd0, b} & mask;
        if (op != 2'b11 && a[w-1]) ae = ae | ~mask;
        if (op[1] == 1'b0 && b[w-1]) be = be | ~mask;
        p = ae * be;
        if (op == 2'b00) return 32'(p & mask);
        return 32'((p >> w) & mask);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ph[i]      <= 0;
                zero_ok[i] <= 1'b1;
            end else if (ph[i] == 0) begin
                if (in_valid_s[i]) begin
                    ph[i]         <= 1;
                    exp_res[i]    <= ref_mul((i == 0) ? 32 : 16, a_s[i], b_s[i], op_s[i]);
                    exp_lit_en[i] <= lit_en_s[i];
                    exp_lit[i]    <= lit_s[i];
                end
            end else if (flush_s[i]) begin
                ph[i] <= 0;
            end else if (ph[i] == lat_of(i)) begin
                if (out_ready_s[i]) ph[i] <= 0;
            end else begin
                ph[i] <= ph[i] + 1;
                if (ph[i] + 1 == lat_of(i)) zero_ok[i] <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    task automatic check(input string name, input int i, input logic [31:0] got,
                         input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_mis++;
            $display("FAIL %s w%0d t=%0t got=%h expected=%h", name, (i == 0) ? 32 : 16,
                     $time, got, expv);
        end
    endtask

    task automatic check_inst(input int i, input logic ir, input logic ov,
                              input logic bz, input logic [31:0] mo);
        int lat;
        lat = lat_of(i);
        check("in_ready",  i, {31'd0, ir}, {31'd0, ph[i] == 0});
        check("mult_busy", i, {31'd0, bz}, {31'd0, (ph[i] >= 1) && (ph[i] < lat)});
        check("out_valid", i, {31'd0, ov}, {31'd0, ph[i] == lat});
        if (ph[i] == lat) begin
            check("mult_o", i, mo, exp_res[i]);
            if (exp_lit_en[i]) begin
                check("mult_o_literal", i, mo, exp_lit[i]);
                check("model_literal",  i, exp_res[i], exp_lit[i]);
            end
        end else if (ph[i] == 0 && zero_ok[i]) begin
            check("mult_o_reset", i, mo, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, in_ready32, out_valid32, busy32, mult_o32);
            check_inst(1, in_ready16, out_valid16, busy16, {16'd0, mult_o16});
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge with the instance idle; returns at the negedge
    // where it is idle again. A junk request is pulsed during ITER and must
    // be ignored.
    task automatic issue(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input bit le, input logic [31:0] l,
                         input int stall);
        int lat;
        lat = lat_of(s);
        in_valid_s[s]  = 1'b1;
        a_s[s]         = a;
        b_s[s]         = b;
        op_s[s]        = op;
        lit_en_s[s]    = le;
        lit_s[s]       = l;
        out_ready_s[s] = (stall == 0);
        @(negedge clk);
        in_valid_s[s] = 1'b0;
        @(negedge clk);
        in_valid_s[s] = 1'b1;
        a_s[s]        = ~a;
        b_s[s]        = b ^ 32'h5a5a;
        op_s[s]       = op + 2'd1;
        @(negedge clk);
        in_valid_s[s] = 1'b0;
        repeat (lat - 3 + stall) @(negedge clk);
        out_ready_s[s] = 1'b1;
        @(negedge clk);
    endtask

    // Start an operation and kill it at phase at_ph by flush (kind 0) or
    // reset (kind 1); out_ready stays high so a DONE-phase flush collides.
    task automatic abort_op(input int s, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input int at_ph, input int kind);
        in_valid_s[s]  = 1'b1;
        a_s[s]         = a;
        b_s[s]         = b;
        op_s[s]        = op;
        lit_en_s[s]    = 1'b0;
        out_ready_s[s] = 1'b1;
        @(negedge clk);
        in_valid_s[s] = 1'b0;
        repeat (at_ph - 1) @(negedge clk);
        if (kind == 0) flush_s[s] = 1'b1;
        else           rst_n      = 1'b0;
        @(negedge clk);
        flush_s[s] = 1'b0;
        if (kind == 1) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 32'h0000;
            1:       return 32'hFFFF;
            2:       return 32'h8000;
            3:       return 32'h7FFF;
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Flush while idle changes nothing.
        flush_s[0] = 1'b1;
        @(negedge clk);
        flush_s[0] = 1'b0;
        @(negedge clk);

        // WIDTH=32 directed vectors
        issue(0, 32'h0000_0007, 32'hFFFF_FFFD, 2'b00, 1'b1, 32'hFFFF_FFEB, 0);
        issue(0, 32'h8000_0000, 32'h8000_0000, 2'b01, 1'b1, 32'h4000_0000, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1, 32'hFFFF_FFFE, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 1'b1, 32'hFFFF_FFFF, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'h0000_0001, 0);

        // Backpressure for 5 cycles, then an immediate new request.
        issue(0, 32'h0000_0006, 32'h0000_0007, 2'b00, 1'b1, 32'h0000_002A, 5);
        issue(0, 32'h0000_0003, 32'h0000_0005, 2'b00, 1'b1, 32'h0000_000F, 0);

        // Flush at ITER digit 5 (phase 7), then a full-latency MUL.
        abort_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 7, 0);
        issue(0, 32'h0000_0003, 32'h0000_0005, 2'b00, 1'b1, 32'h0000_000F, 0);

        // Reset at ITER digit 5, then a full-latency MUL.
        abort_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 7, 1);
        issue(0, 32'h0000_0003, 32'h0000_0005, 2'b00, 1'b1, 32'h0000_000F, 0);

        // Flush colliding with out_ready in DONE: no delivery, back to IDLE.
        abort_op(0, 32'h0000_0009, 32'h0000_0009, 2'b00, LAT32, 0);
        issue(0, 32'hFFFF_FFFE, 32'h0000_0004, 2'b01, 1'b1, 32'hFFFF_FFFF, 0);

        // WIDTH=16 directed vectors
        issue(1, 32'h8000, 32'h7FFF, 2'b00, 1'b1, 32'h8000, 0);
        issue(1, 32'h8000, 32'h7FFF, 2'b01, 1'b1, 32'hC000, 0);
        issue(1, 32'h8000, 32'h7FFF, 2'b10, 1'b1, 32'hC000, 0);
        issue(1, 32'h8000, 32'h7FFF, 2'b11, 1'b1, 32'h3FFF, 2);
        abort_op(1, 32'h8000, 32'h8000, 2'b01, 4, 0);

        // Random operands and modes against the reference model.
        for (int k = 0; k < 600; k++)
            issue(0, rnd32(), rnd32(), 2'($urandom_range(0, 3)), 1'b0, 32'd0,
                  $urandom_range(0, 2));
        for (int k = 0; k < 1500; k++)
            issue(1, rnd16(), rnd16(), 2'($urandom_range(0, 3)), 1'b0, 32'd0,
                  $urandom_range(0, 2));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
